// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants for the fetch stage.
//   INSTR_W    : instruction width in bits
//   PC_STEP    : PC increment between sequential fetches (bytes)
//   ALIGN_MASK : low PC bits that must be zero for an aligned fetch address
// Types that depend on the PC width (queue entries of N+32 bits) live in the
// modules that own the width parameter, not here.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int         INSTR_W    = 32;
    localparam int         PC_STEP    = 4;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO with asynchronous reset and a single-cycle flush.
// Read data is combinational from the head slot (no bypass from wdata).
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset, empties the FIFO and zeroes storage
//   flush  : discards all entries on the next edge; has priority over push/pop
//   push   : write wdata at the tail (ignored when full unless popping too)
//   pop    : retire the head entry (ignored when empty)
//   wdata  : entry to write
//   rdata  : head entry (stale when empty)
//   count  : number of stored entries, 0..DEPTH
//   full   : count == DEPTH
//   empty  : count == 0
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO may still accept a write when the head leaves in the same
    // cycle; the slot being written is the one being read, and the read sees
    // the old contents until the edge.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    assign rdata = mem[rd_ptr];

    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
    // by simple overflow. Flush returns everything to the reset position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so the head outputs read as zero out of
    // reset. Flush leaves the contents alone; they are only stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!flush && do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Fetch stage with a decoupling instruction queue. The PC drives a
// combinational instruction memory; each accepted {PC, instruction} pair is
// queued and handed to decode over a valid/ready handshake. A redirect loads
// a new PC and flushes the queue.
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : redirect targets are forced to a 4-byte boundary and a sticky
//               misalign_F flag records that a misaligned target was seen
//   undefined : targets are loaded unmodified and misalign_F is tied low
// Ports:
//   clk           : rising-edge clock
//   reset         : asynchronous active-high reset
//   PCSrc_F       : redirect request, highest priority
//   PCBranch_F    : redirect target
//   imem_addr_F   : instruction memory address (the PC register)
//   imem_rdata_F  : instruction at imem_addr_F, same cycle
//   instr_valid_D : queue head valid
//   instr_ready_D : decode accepts the head
//   instr_D       : head instruction
//   instr_pc_D    : PC of the head instruction
//   misalign_F    : sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int             N        = 64,
    parameter int             DEPTH    = 4,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCSrc_F,
    input  logic [N-1:0]       PCBranch_F,
    output logic [N-1:0]       imem_addr_F,
    input  logic [INSTR_W-1:0] imem_rdata_F,
    output logic               instr_valid_D,
    input  logic               instr_ready_D,
    output logic [INSTR_W-1:0] instr_D,
    output logic [N-1:0]       instr_pc_D,
    output logic               misalign_F
);

    localparam int ENTRY_W = N + INSTR_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic [N-1:0]       pc_q;
    logic [N-1:0]       redirect_target;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic               fifo_full_unused;

    assign imem_addr_F = pc_q;

    // A redirect hides the head combinationally so decode never takes an
    // instruction from the path being abandoned.
    assign instr_valid_D = ~fifo_empty & ~PCSrc_F;
    assign pop           = instr_valid_D & instr_ready_D;
    assign push          = ~PCSrc_F & ((fifo_count < CNT_W'(DEPTH)) | pop);

    assign fifo_wdata = {pc_q, imem_rdata_F};
    assign instr_D    = fifo_rdata[INSTR_W-1:0];
    assign instr_pc_D = fifo_rdata[ENTRY_W-1:INSTR_W];

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;
    logic target_misaligned;

    assign target_misaligned = |(PCBranch_F & N'(ALIGN_MASK));
    assign redirect_target   = PCBranch_F & ~N'(ALIGN_MASK);
    assign misalign_F        = misalign_q;

    // Once a misaligned redirect is seen the flag stays up until reset, so
    // software can poll it long after the event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (PCSrc_F && target_misaligned) begin
            misalign_q <= 1'b1;
        end
    end
`else
    assign redirect_target = PCBranch_F;
    assign misalign_F      = 1'b0;
`endif

    // PC register: redirect wins, otherwise advance only when the fetched
    // word is actually captured; the add wraps silently at 2^N.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (PCSrc_F) begin
            pc_q <= redirect_target;
        end else if (push) begin
            pc_q <= pc_q + N'(PC_STEP);
        end
    end

    // The full flag duplicates the count comparison used for push, so it is
    // left unused here.
    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (PCSrc_F),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full_unused),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue (N = 64, DEPTH = 4, RESET_PC = 0x100).
// The instruction memory is modelled as addr[31:0] ^ 0xAAAA. A reference
// model of the PC and queue pushes expected {PC, instruction} entries into a
// scoreboard queue and pops them when decode is expected to accept one.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int          N        = 64;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h100;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrc_F;
    logic [63:0] PCBranch_F;
    logic [63:0] imem_addr_F;
    logic [31:0] imem_rdata_F;
    logic        instr_valid_D;
    logic        instr_ready_D;
    logic [31:0] instr_D;
    logic [63:0] instr_pc_D;
    logic        misalign_F;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      sb[$];
    logic [63:0] model_pc;
    logic        model_misalign;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    assign imem_rdata_F = imem_addr_F[31:0] ^ 32'h0000_AAAA;

    fetch_queue #(
        .N        (N),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .PCSrc_F       (PCSrc_F),
        .PCBranch_F    (PCBranch_F),
        .imem_addr_F   (imem_addr_F),
        .imem_rdata_F  (imem_rdata_F),
        .instr_valid_D (instr_valid_D),
        .instr_ready_D (instr_ready_D),
        .instr_D       (instr_D),
        .instr_pc_D    (instr_pc_D),
        .misalign_F    (misalign_F)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Asynchronous reset pulse mid-cycle: outputs must reach reset values
    // before any clock edge.
    task automatic doReset();
        reset = 1'b1;
        #1;
        checkOutput("rst_valid",    {63'b0, instr_valid_D}, 64'd0);
        checkOutput("rst_addr",     imem_addr_F, RESET_PC);
        checkOutput("rst_misalign", {63'b0, misalign_F}, 64'd0);
        checkOutput("rst_instr",    {32'b0, instr_D}, 64'd0);
        checkOutput("rst_instr_pc", instr_pc_D, 64'd0);
        sb.delete();
        model_pc       = RESET_PC;
        model_misalign = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance
    // the model, then move past the next rising edge.
    task automatic applyStimulus(input logic src, input logic [63:0] target, input logic ready);
        bit     exp_valid;
        bit     exp_pop;
        bit     exp_push;
        entry_t head;
        PCSrc_F       = src;
        PCBranch_F    = target;
        instr_ready_D = ready;
        #1;
        exp_valid = (sb.size() != 0) && !src;
        exp_pop   = exp_valid && ready;
        exp_push  = !src && ((sb.size() < DEPTH) || exp_pop);
        checkOutput("valid",     {63'b0, instr_valid_D}, {63'b0, exp_valid});
        checkOutput("imem_addr", imem_addr_F, model_pc);
        checkOutput("misalign",  {63'b0, misalign_F}, {63'b0, model_misalign});
        if (exp_pop) begin
            head = sb.pop_front();
            checkOutput("instr_pc", instr_pc_D, head.pc);
            checkOutput("instr",    {32'b0, instr_D}, {32'b0, head.instr});
        end
        if (src) begin
            sb.delete();
`ifdef FETCH_ALIGN_CHECK_EN
            model_pc = {target[63:2], 2'b00};
            if (target[1:0] != 2'b00) model_misalign = 1'b1;
`else
            model_pc = target;
`endif
        end else if (exp_push) begin
            sb.push_back('{pc: model_pc, instr: model_pc[31:0] ^ 32'h0000_AAAA});
            model_pc = model_pc + 64'd4;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        PCSrc_F       = 1'b0;
        PCBranch_F    = '0;
        instr_ready_D = 1'b1;
        #2;
        $display("[TB] reset and streaming fetch");
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 64'h0, 1'b1);

        $display("[TB] back-pressure from a fresh reset");
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 64'h0, 1'b0);
        checkOutput("stall_addr", imem_addr_F, 64'h110);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 64'h0, 1'b1);

        $display("[TB] redirect with a full queue");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 64'h0, 1'b0);
        applyStimulus(1'b1, 64'h2000, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 64'h0, 1'b1);

        $display("[TB] redirect into an empty queue with ready toggling");
        applyStimulus(1'b1, 64'h3000, 1'b0);
        applyStimulus(1'b1, 64'h3000, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 64'h0, (i % 2) == 1);

        $display("[TB] PC wrap at 2^64");
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        applyStimulus(1'b0, 64'h0, 1'b1);
        checkOutput("wrap_addr", imem_addr_F, 64'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 64'h0, 1'b1);

        $display("[TB] misaligned redirect");
        applyStimulus(1'b1, 64'h2002, 1'b1);
`ifdef FETCH_ALIGN_CHECK_EN
        checkOutput("mis_addr", imem_addr_F, 64'h2000);
        checkOutput("mis_flag", {63'b0, misalign_F}, 64'd1);
`else
        checkOutput("mis_addr", imem_addr_F, 64'h2002);
        checkOutput("mis_flag", {63'b0, misalign_F}, 64'd0);
`endif
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 64'h0, 1'b1);
        doReset();
        applyStimulus(1'b0, 64'h0, 1'b1);
        applyStimulus(1'b0, 64'h0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised fetch stage with a decoupling instruction queue. Drives the PC into a combinational instruction memory and captures {PC, instruction} pairs into a DEPTH-entry FIFO. Presents them to decode over a valid/ready handshake. A taken branch redirects the PC and flushes the queue, so decode can stall without stalling instruction-memory reads.

## Interface
- N, 64: PC / address width.
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 0: PC value loaded on reset.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears the PC to RESET_PC and empties the queue.
- PCSrc_F  in  1  redirect request; takes priority over everything else in its cycle.
- PCBranch_F  in  N  redirect target, sampled when PCSrc_F = 1.
- imem_addr_F  out  N  equals the PC register; no other logic on this path.
- imem_rdata_F  in  32  instruction at imem_addr_F, same cycle.
- instr_valid_D  out  1  queue head valid.
- instr_ready_D  in  1  decode accepts the head.
- instr_D  out  32  head instruction.
- instr_pc_D  out  N  head PC.
- misalign_F  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- Status terms:
  - pop = instr_valid_D & instr_ready_D.
  - push = !PCSrc_F & (count < DEPTH | pop).
- Push cycle: queue writes {imem_addr_F, imem_rdata_F}; PC <= PC + 4, modulo 2^N, so the PC wraps silently.
- No-push cycle without redirect: PC holds.
- Full queue with a simultaneous pop: push is allowed and count is unchanged.
- Empty queue: no bypass; instr_valid_D = 0 and instr_D / instr_pc_D hold stale data.
- Redirect cycle (PCSrc_F = 1):
  - PC <= PCBranch_F.
  - Count <= 0 and read/write pointers reset.
  - No push.
  - instr_valid_D forced to 0 combinationally, so no pop occurs.
- instr_valid_D = (count != 0) & !PCSrc_F.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Count is log2(DEPTH)+1 bits wide.
- Queue order is strict FIFO; instr_pc_D always matches the PC at which instr_D was fetched.
- Reset mid-operation: all queued entries are discarded immediately. Outputs go to reset values asynchronously.

## Timing
- Reset values:
  - imem_addr_F = RESET_PC.
  - instr_valid_D = 0.
  - misalign_F = 0.
  - instr_D / instr_pc_D = 0.
- Fetch-to-decode latency: 1 cycle. An instruction read in cycle t is valid at instr_valid_D in cycle t+1.
- Redirect-to-first-valid latency: 2 cycles. The target is fetched in cycle t+1 and valid in cycle t+2.
- Steady state with instr_ready_D = 1: one instruction per cycle.
- Back-pressure: with instr_ready_D = 0, the queue fills in DEPTH cycles, then the PC stalls.
- Back-pressure release: throughput resumes the cycle ready rises.
- All state updates occur on the rising edge of clk, except reset.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - On a redirect with PCBranch_F[1:0] != 0, the PC loads {PCBranch_F[N-1:2], 2'b00}.
  - misalign_F sets on the next edge and stays set until reset.
- FETCH_ALIGN_CHECK_EN undefined:
  - The target is loaded unmodified.
  - misalign_F is tied to 0.
  - The port list is identical in both builds.

## Structure
- Package fetch_pkg holds:
  - INSTR_W = 32.
  - PC_STEP = 4.
  - The alignment mask constant.
- Parameter-dependent types (entry width N+32) are not placed in the package.
- Sub-module fetch_fifo: synchronous FIFO with async reset and a single-cycle flush input, parametrised by width and DEPTH. It exposes count, full and empty.
- fetch_queue holds the PC register, push/pop logic and alignment check, and instantiates fetch_fifo.

## Test plan
- Reset release, RESET_PC = 0x100, ready = 1, imem returns addr ^ 0xAAAA -> decode receives PCs 0x100, 0x104, 0x108 on consecutive cycles starting 1 cycle after release, with matching data.
- ready = 0 for 8 cycles, DEPTH = 4 -> count saturates at 4 and imem_addr_F holds at 0x110 (RESET_PC 0x100). On ready = 1, PCs 0x100–0x10C drain in order with no gap.
- Full queue, PCSrc_F = 1, PCBranch_F = 0x2000 -> instr_valid_D = 0 in that cycle. Queued entries are never delivered. The next delivered instruction_pc is 0x2000, 2 cycles later.
- PCSrc_F asserted while queue empty and ready toggling -> no spurious pop. First valid is the target 2 cycles later.
- PC = 2^64 − 4, ready = 1 -> next fetch address is 0x0 and no error is flagged.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x2002 -> imem_addr_F = 0x2000 and misalign_F = 1, held until reset. Without FETCH_ALIGN_CHECK_EN -> imem_addr_F = 0x2002 and misalign_F = 0.
